// File: rtl/tx_probe_pkg.sv
// Shared types and defaults for the transistor probe evaluator.
package tx_probe_pkg;

   localparam int CNT_W_DEF   = 6;
   localparam int THRESH_DEF  = 4;
   localparam int TIMEOUT_DEF = 63;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM_A,
      S_ACC_A,
      S_ARM_B,
      S_ACC_B,
      S_DECIDE,
      S_HOLD
   } state_t;

   typedef enum logic [1:0] {
      V_OPEN  = 2'b00,
      V_NPN   = 2'b01,
      V_PNP   = 2'b10,
      V_SHORT = 2'b11
   } verdict_t;

   // Channel A conducting alone is NPN, channel B alone is PNP.
   function automatic verdict_t classify(input logic a_on, input logic b_on);
      return verdict_t'({b_on, a_on});
   endfunction

endpackage

// File: rtl/tx_probe_eval_sense_sync.sv
// Two-flop synchronizer for the asynchronous comparator output.
module sense_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/tx_probe_eval.sv
// Probe measurement sequencer: counts sense highs in the phase_a and phase_b
// windows, classifies the device and holds the result until accepted.
module tx_probe_eval
   import tx_probe_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int THRESH  = THRESH_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             phase_a,
   input  logic             phase_b,
   input  logic             sense,
   input  logic             res_ready,
   output logic             res_valid,
   output logic [1:0]       verdict,
   output logic             timeout,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b,
   output logic             busy
);

   localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [31:0]       THRESH_U  = 32'(THRESH);

   state_t            state, state_nx;
   verdict_t          verdict_q;
   logic [WAIT_W-1:0] wait_cnt;
   logic              sense_s;

   logic clr_meas, inc_a, inc_b, wait_inc, wait_clr, ld_verdict, ld_timeout;

   sense_sync u_sense_sync (
      .clk (clk),
      .rst (rst),
      .d   (sense),
      .q   (sense_s)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      clr_meas   = 1'b0;
      inc_a      = 1'b0;
      inc_b      = 1'b0;
      wait_inc   = 1'b0;
      wait_clr   = 1'b0;
      ld_verdict = 1'b0;
      ld_timeout = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx = S_ARM_A;
               clr_meas = 1'b1;
            end
         end
         S_ARM_A: begin
            if (phase_a) begin
               state_nx = S_ACC_A;
               wait_clr = 1'b1;
            end else if (wait_cnt == WAIT_LAST) begin
               // this cycle is the TIMEOUT-th one spent waiting
               state_nx   = S_HOLD;
               ld_timeout = 1'b1;
               wait_clr   = 1'b1;
            end else begin
               wait_inc = 1'b1;
            end
         end
         S_ACC_A: begin
            inc_a = sense_s;
            if (!phase_a) state_nx = S_ARM_B;
         end
         S_ARM_B: begin
            if (phase_b) begin
               state_nx = S_ACC_B;
               wait_clr = 1'b1;
            end else if (wait_cnt == WAIT_LAST) begin
               state_nx   = S_HOLD;
               ld_timeout = 1'b1;
               wait_clr   = 1'b1;
            end else begin
               wait_inc = 1'b1;
            end
         end
         S_ACC_B: begin
            inc_b = sense_s;
            if (!phase_b) state_nx = S_DECIDE;
         end
         S_DECIDE: begin
            ld_verdict = 1'b1;
            state_nx   = S_HOLD;
         end
         S_HOLD: begin
            if (res_ready) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_a     <= '0;
         cnt_b     <= '0;
         wait_cnt  <= '0;
         timeout   <= 1'b0;
         verdict_q <= V_OPEN;
      end else begin
         if (clr_meas) begin
            cnt_a   <= '0;
            cnt_b   <= '0;
            timeout <= 1'b0;
         end
         if (inc_a && cnt_a != CNT_MAX) cnt_a <= cnt_a + 1'b1;
         if (inc_b && cnt_b != CNT_MAX) cnt_b <= cnt_b + 1'b1;
         if (clr_meas || wait_clr)  wait_cnt <= '0;
         else if (wait_inc)         wait_cnt <= wait_cnt + 1'b1;
         if (ld_timeout) begin
            timeout   <= 1'b1;
            verdict_q <= V_OPEN;
         end
         if (ld_verdict) begin
            verdict_q <= classify(32'(cnt_a) >= THRESH_U, 32'(cnt_b) >= THRESH_U);
         end
      end
   end

   assign verdict   = verdict_q;
   assign res_valid = (state == S_HOLD);
   assign busy      = (state != S_IDLE);

endmodule

// File: doc/tx_probe_eval.md
TX_PROBE_EVAL -- requirements
Module: tx_probe_eval

Interface
REQ-001 Parameter CNT_W, default 6, sets the width of the sample counters.
REQ-002 Parameter THRESH, default 4, sets the minimum high-sample count for a conducting window.
REQ-003 Parameter TIMEOUT, default 63, sets the maximum number of cycles spent waiting for a phase to start.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle request to begin one probe measurement.
REQ-007 phase_a  in  1  channel-1 drive window from the phase generator.
REQ-008 phase_b  in  1  channel-2 drive window from the phase generator.
REQ-009 sense  in  1  asynchronous comparator output from the probe node.
REQ-010 res_ready  in  1  consumer accepts the result.
REQ-011 res_valid  out  1  result available.
REQ-012 verdict  out  2  00 OPEN, 01 NPN, 10 PNP, 11 SHORT.
REQ-013 timeout  out  1  the measurement was aborted because a phase did not start.
REQ-014 cnt_a  out  CNT_W  count of high sense samples taken in the phase_a window.
REQ-015 cnt_b  out  CNT_W  count of high sense samples taken in the phase_b window.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 sense SHALL pass through a 2-flop synchronizer; sense_s lags sense by 2 cycles.
REQ-018 FSM states SHALL be IDLE, ARM_A, ACC_A, ARM_B, ACC_B, DECIDE and HOLD.
REQ-019 IDLE -> ARM_A on start; this transition clears cnt_a, cnt_b, timeout and the wait counter.
REQ-020 ARM_A -> ACC_A on the first cycle phase_a=1; ACC_A -> ARM_B on the first cycle phase_a=0.
REQ-021 ARM_B -> ACC_B on the first cycle phase_b=1; ACC_B -> DECIDE on the first cycle phase_b=0.
REQ-022 In ACC_A, cnt_a SHALL increment on each cycle sense_s=1; in ACC_B, cnt_b SHALL increment on each cycle sense_s=1.
REQ-023 Both counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-024 In ARM_A and ARM_B, a wait counter SHALL increment each cycle; it SHALL clear when the FSM leaves ARM_A.
REQ-025 When the wait counter reaches TIMEOUT, the FSM SHALL go to HOLD with timeout=1 and verdict=00.
REQ-026 DECIDE lasts one cycle and computes A=(cnt_a>=THRESH) and B=(cnt_b>=THRESH).
REQ-027 Verdict encoding: A&!B -> 01; !A&B -> 10; A&B -> 11; neither -> 00.
REQ-028 HOLD SHALL drive res_valid=1; verdict, timeout, cnt_a and cnt_b SHALL stay stable until res_valid&res_ready.
REQ-029 HOLD -> IDLE on res_valid&res_ready; res_valid SHALL be 0 from the next cycle.
REQ-030 start SHALL be ignored while busy=1.
REQ-031 phase_b SHALL be ignored outside ARM_B and ACC_B, including when phase_a and phase_b are high together; phase_a SHALL be ignored outside ARM_A and ACC_A.
REQ-032 Latency from the phase_b falling edge to res_valid=1 SHALL be 2 cycles (ACC_B->DECIDE, then DECIDE->HOLD).

Reset
REQ-033 While rst=1: state=IDLE; res_valid, busy and timeout=0; verdict=00; cnt_a, cnt_b and the wait counter=0; synchronizer flops=0.
REQ-034 rst mid-measurement SHALL abort the measurement with no res_valid pulse.
REQ-035 rst SHALL take priority over start.

Structure
REQ-036 A shared package tx_probe_pkg SHALL hold the state enum, the verdict enum (OPEN, NPN, PNP, SHORT) and the default parameter constants.
REQ-037 The synchronizer SHALL be a separate sub-module sense_sync.

Verification
REQ-038 start; phase_a high 10 cycles with sense=1; phase_b high 10 cycles with sense=0 -> cnt_a=10 (less the 2-cycle synchronizer edge), cnt_b=0, verdict=01, res_valid 2 cycles after phase_b falls.
REQ-039 Same as REQ-038 with sense inverted -> verdict=10; sense=1 in both windows -> verdict=11; sense=0 in both windows -> verdict=00 with timeout=0.
REQ-040 start with phase_a never asserted -> after 63 cycles, res_valid=1, timeout=1, verdict=00.
REQ-041 sense=1 for 80 cycles of phase_a with CNT_W=6 -> cnt_a=63, no wrap.
REQ-042 Hold res_ready=0 for 5 cycles in HOLD and pulse start -> outputs stable, start ignored; then res_ready=1 -> IDLE next cycle.
REQ-043 rst asserted during ACC_B -> next cycle all outputs at reset values and res_valid never asserts.
